// File: rtl/fetch_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_seq_ctrl
//  Purpose  : Fetch sequencer driving PC control and the single-outstanding
//             instruction-memory handshake, with redirect priority and a
//             one-entry hold buffer for load-use stalls.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_seq_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [ADDR_W-1:0]  pc,
    output logic               pc_stall,
    output logic               pc_branch_jump,
    output logic [ADDR_W-1:0]  pc_new_pc,

    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_instr,

    input  logic               trap,
    input  logic [ADDR_W-1:0]  trap_vector,
    input  logic               ex_redirect,
    input  logic [ADDR_W-1:0]  ex_target,
    input  logic               id_jump,
    input  logic [ADDR_W-1:0]  id_target,

    input  logic               hold,
    output logic               fetch_valid,
    output logic [INSTR_W-1:0] fetch_instr,
    output logic [ADDR_W-1:0]  fetch_pc,
    output logic               flush_if_id
);

    localparam logic [2:0] S_BOOT  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_KILL  = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nx;
    logic [INSTR_W-1:0] r_buf_instr;
    logic [ADDR_W-1:0]  r_buf_pc;
    logic [ADDR_W-1:0]  r_pend;

    logic               w_redir;
    logic [ADDR_W-1:0]  w_tgt;
    logic               w_buf_load;
    logic               w_pend_load;

    assign w_redir = trap | ex_redirect | id_jump;

    always_comb begin
        if (trap) begin
            w_tgt = trap_vector;
        end else if (ex_redirect) begin
            w_tgt = ex_target;
        end else begin
            w_tgt = id_target;
        end
    end

    // Buffer only a response that survives (no redirect) but cannot be consumed.
    assign w_buf_load  = (r_state == S_WAIT) && imem_rsp_valid && !w_redir && hold;
    // Newest redirect wins while the killed response is still in flight.
    assign w_pend_load = ((r_state == S_WAIT) && !imem_rsp_valid && w_redir) ||
                         ((r_state == S_KILL) && w_redir);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_instr <= '0;
            r_buf_pc    <= '0;
            r_pend      <= '0;
        end else begin
            if (w_buf_load) begin
                r_buf_instr <= imem_rsp_instr;
                r_buf_pc    <= pc;
            end
            if (w_pend_load) begin
                r_pend <= w_tgt;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_BOOT: begin
                w_state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                if (!w_redir && imem_req_ready) begin
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_nx = (!w_redir && hold) ? S_HOLD : S_ISSUE;
                end else if (w_redir) begin
                    w_state_nx = S_KILL;
                end
            end
            S_HOLD: begin
                if (w_redir || !hold) begin
                    w_state_nx = S_ISSUE;
                end
            end
            S_KILL: begin
                if (imem_rsp_valid) begin
                    w_state_nx = S_ISSUE;
                end
            end
            default: begin
                w_state_nx = S_BOOT;
            end
        endcase
    end

    always_comb begin
        pc_stall       = 1'b1;
        pc_branch_jump = 1'b0;
        pc_new_pc      = '0;
        imem_req_valid = 1'b0;
        fetch_valid    = 1'b0;
        fetch_instr    = '0;
        fetch_pc       = '0;
        flush_if_id    = (r_state != S_BOOT) && w_redir;

        case (r_state)
            S_ISSUE: begin
                imem_req_valid = !w_redir;
                if (w_redir) begin
                    pc_stall       = 1'b0;
                    pc_branch_jump = 1'b1;
                    pc_new_pc      = w_tgt;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid && w_redir) begin
                    pc_stall       = 1'b0;
                    pc_branch_jump = 1'b1;
                    pc_new_pc      = w_tgt;
                end else if (imem_rsp_valid && !hold) begin
                    pc_stall    = 1'b0;
                    fetch_valid = 1'b1;
                    fetch_instr = imem_rsp_instr;
                    fetch_pc    = pc;
                end
            end
            S_HOLD: begin
                if (w_redir) begin
                    pc_stall       = 1'b0;
                    pc_branch_jump = 1'b1;
                    pc_new_pc      = w_tgt;
                end else begin
                    fetch_valid = 1'b1;
                    fetch_instr = r_buf_instr;
                    fetch_pc    = r_buf_pc;
                    pc_stall    = hold;
                end
            end
            S_KILL: begin
                if (imem_rsp_valid) begin
                    pc_stall       = 1'b0;
                    pc_branch_jump = 1'b1;
                    pc_new_pc      = w_redir ? w_tgt : r_pend;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_seq_ctrl
//  Purpose  : Bench for fetch_seq_ctrl with PC-register and memory models.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_seq_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc_q;
    logic        pc_stall, pc_branch_jump;
    logic [31:0] pc_new_pc;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_rsp_instr;
    logic        trap, ex_redirect, id_jump, hold;
    logic [31:0] trap_vector, ex_target, id_target;
    logic        fetch_valid, flush_if_id;
    logic [31:0] fetch_instr, fetch_pc;

    int          vectors;
    int          errors;

    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat_mode;
    logic        mem_force;
    logic [31:0] mem_force_val;

    fetch_seq_ctrl #(.ADDR_W(32), .INSTR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc_q),
        .pc_stall       (pc_stall),
        .pc_branch_jump (pc_branch_jump),
        .pc_new_pc      (pc_new_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_instr (imem_rsp_instr),
        .trap           (trap),
        .trap_vector    (trap_vector),
        .ex_redirect    (ex_redirect),
        .ex_target      (ex_target),
        .id_jump        (id_jump),
        .id_target      (id_target),
        .hold           (hold),
        .fetch_valid    (fetch_valid),
        .fetch_instr    (fetch_instr),
        .fetch_pc       (fetch_pc),
        .flush_if_id    (flush_if_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic clear_inputs();
        trap = 0; ex_redirect = 0; id_jump = 0; hold = 0; imem_req_ready = 0;
        trap_vector = 0; ex_target = 0; id_target = 0;
    endtask

    // Present this cycle's memory response, then move to the sampling point.
    task automatic half();
        imem_rsp_valid = mem_busy && (mem_cnt == 0);
        imem_rsp_instr = imem_rsp_valid ? (mem_force ? mem_force_val : mem_word(mem_addr)) : 32'h0;
        @(negedge clk);
    endtask

    // PC register and memory update at the rising edge.
    task automatic advance();
        logic [31:0] pc_nx;
        logic [31:0] pc_old;
        logic        take;
        take   = imem_req_valid && imem_req_ready;
        pc_old = pc_q;
        if (pc_branch_jump)  pc_nx = pc_new_pc;
        else if (!pc_stall)  pc_nx = pc_q + 32'd4;
        else                 pc_nx = pc_q;
        @(posedge clk);
        #1;
        pc_q = rst ? 32'h0 : pc_nx;
        if (imem_rsp_valid)  mem_busy = 1'b0;
        else if (mem_busy)   mem_cnt  = mem_cnt - 1;
        if (take) begin
            mem_busy = 1'b1;
            mem_addr = pc_old;
            mem_cnt  = (lat_mode == 0) ? int'($urandom_range(0, 2)) : lat_mode - 1;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1; pc_q = 0; mem_busy = 0; mem_cnt = 0; mem_force = 0;
        imem_rsp_valid = 0; imem_rsp_instr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        trap = 1; trap_vector = 32'h40; imem_req_ready = 1;
        #1;
        vectors++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b want 1", pc_stall); end
        vectors++;
        if ({pc_branch_jump, pc_new_pc, imem_req_valid, fetch_valid, fetch_instr, fetch_pc, flush_if_id} !== '0) begin
            errors++; $display("FAIL reset_idle: bj=%b npc=%h req=%b fv=%b fi=%h fp=%h fl=%b want all 0",
                pc_branch_jump, pc_new_pc, imem_req_valid, fetch_valid, fetch_instr, fetch_pc, flush_if_id);
        end
        do_reset();
        half();
        vectors++; if (pc_stall !== 1'b1 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL boot_cycle: stall=%b req=%b want 1/0", pc_stall, imem_req_valid); end
        advance();
        imem_req_ready = 0;
        half();
        vectors++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL issue_after_boot: req=%b want 1", imem_req_valid); end
        advance();
    endtask

    task automatic test_straight_line();
        do_reset(); lat_mode = 1; imem_req_ready = 1;
        half(); advance();
        for (int k = 0; k < 5; k++) begin
            half();
            vectors++; if (imem_req_valid !== 1'b1 || fetch_valid !== 1'b0) begin errors++; $display("FAIL straight_issue%0d: req=%b fv=%b want 1/0", k, imem_req_valid, fetch_valid); end
            advance();
            half();
            vectors++;
            if (fetch_valid !== 1'b1 || fetch_pc !== 32'(4 * k) || fetch_instr !== mem_word(32'(4 * k)) || flush_if_id !== 1'b0 || pc_stall !== 1'b0) begin
                errors++; $display("FAIL straight_fetch%0d: fv=%b pc=%h instr=%h fl=%b stall=%b want 1/%h/%h/0/0",
                    k, fetch_valid, fetch_pc, fetch_instr, flush_if_id, pc_stall, 32'(4 * k), mem_word(32'(4 * k)));
            end
            advance();
        end
        vectors++; if (pc_q !== 32'h14) begin errors++; $display("FAIL straight_pc_end: got %h want 00000014", pc_q); end
    endtask

    task automatic test_backpressure();
        do_reset(); lat_mode = 1; imem_req_ready = 0;
        half(); advance();
        for (int k = 0; k < 3; k++) begin
            half();
            vectors++; if (imem_req_valid !== 1'b1 || pc_stall !== 1'b1 || pc_branch_jump !== 1'b0) begin errors++; $display("FAIL bp_wait%0d: req=%b stall=%b bj=%b want 1/1/0", k, imem_req_valid, pc_stall, pc_branch_jump); end
            advance();
        end
        imem_req_ready = 1;
        half(); advance();
        vectors++; if (pc_q !== 32'h0) begin errors++; $display("FAIL bp_pc_before_rsp: got %h want 00000000", pc_q); end
        half();
        vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0) begin errors++; $display("FAIL bp_fetch: fv=%b pc=%h want 1/0", fetch_valid, fetch_pc); end
        advance();
        vectors++; if (pc_q !== 32'h4) begin errors++; $display("FAIL bp_pc_after_rsp: got %h want 00000004", pc_q); end
    endtask

    task automatic test_hold();
        do_reset(); lat_mode = 1; imem_req_ready = 1;
        mem_force = 1; mem_force_val = 32'h0050_0093;
        half(); advance();
        half(); advance();
        hold = 1;
        half();
        vectors++; if (fetch_valid !== 1'b0 || pc_stall !== 1'b1) begin errors++; $display("FAIL hold_capture: fv=%b stall=%b want 0/1", fetch_valid, pc_stall); end
        advance();
        for (int k = 0; k < 4; k++) begin
            half();
            vectors++;
            if (fetch_valid !== 1'b1 || fetch_instr !== 32'h0050_0093 || fetch_pc !== 32'h0 || pc_stall !== 1'b1 || imem_req_valid !== 1'b0) begin
                errors++; $display("FAIL hold_cycle%0d: fv=%b instr=%h pc=%h stall=%b req=%b want 1/00500093/0/1/0",
                    k, fetch_valid, fetch_instr, fetch_pc, pc_stall, imem_req_valid);
            end
            advance();
        end
        hold = 0;
        half();
        vectors++; if (fetch_valid !== 1'b1 || pc_stall !== 1'b0 || pc_branch_jump !== 1'b0) begin errors++; $display("FAIL hold_release: fv=%b stall=%b bj=%b want 1/0/0", fetch_valid, pc_stall, pc_branch_jump); end
        advance();
        vectors++; if (pc_q !== 32'h4) begin errors++; $display("FAIL hold_pc_adv: got %h want 00000004", pc_q); end
        mem_force = 0;
    endtask

    task automatic test_redirect_wait();
        do_reset(); lat_mode = 3; imem_req_ready = 1;
        half(); advance();
        half(); advance();
        ex_redirect = 1; ex_target = 32'h100;
        half();
        vectors++; if (flush_if_id !== 1'b1 || fetch_valid !== 1'b0 || pc_branch_jump !== 1'b0 || pc_stall !== 1'b1) begin errors++; $display("FAIL rw_redirect: fl=%b fv=%b bj=%b stall=%b want 1/0/0/1", flush_if_id, fetch_valid, pc_branch_jump, pc_stall); end
        advance();
        ex_redirect = 0; ex_target = 0;
        half();
        vectors++; if (imem_req_valid !== 1'b0 || pc_stall !== 1'b1 || fetch_valid !== 1'b0) begin errors++; $display("FAIL rw_kill: req=%b stall=%b fv=%b want 0/1/0", imem_req_valid, pc_stall, fetch_valid); end
        advance();
        half();
        vectors++; if (imem_rsp_valid !== 1'b1 || fetch_valid !== 1'b0 || pc_branch_jump !== 1'b1 || pc_new_pc !== 32'h100 || pc_stall !== 1'b0) begin errors++; $display("FAIL rw_discard: rsp=%b fv=%b bj=%b npc=%h stall=%b want 1/0/1/100/0", imem_rsp_valid, fetch_valid, pc_branch_jump, pc_new_pc, pc_stall); end
        advance();
        vectors++; if (pc_q !== 32'h100) begin errors++; $display("FAIL rw_pc: got %h want 00000100", pc_q); end
        half();
        vectors++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rw_reissue: req=%b want 1", imem_req_valid); end
        advance();
    endtask

    task automatic test_simultaneous();
        do_reset(); lat_mode = 1; imem_req_ready = 1;
        half(); advance();
        trap = 1; trap_vector = 32'h80; id_jump = 1; id_target = 32'h200;
        half();
        vectors++; if (pc_new_pc !== 32'h80 || imem_req_valid !== 1'b0 || flush_if_id !== 1'b1 || pc_branch_jump !== 1'b1 || pc_stall !== 1'b0) begin errors++; $display("FAIL sim_trap_id: npc=%h req=%b fl=%b bj=%b stall=%b want 80/0/1/1/0", pc_new_pc, imem_req_valid, flush_if_id, pc_branch_jump, pc_stall); end
        advance();
        vectors++; if (pc_q !== 32'h80) begin errors++; $display("FAIL sim_pc: got %h want 00000080", pc_q); end
        trap = 0; ex_redirect = 1; ex_target = 32'h300;
        half();
        vectors++; if (pc_new_pc !== 32'h300 || pc_branch_jump !== 1'b1) begin errors++; $display("FAIL sim_ex_id: npc=%h bj=%b want 300/1", pc_new_pc, pc_branch_jump); end
        advance();
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        do_reset(); lat_mode = 3; imem_req_ready = 1;
        half(); advance();
        half(); advance();
        imem_req_ready = 0;
        half();
        rst = 1'b1;
        #1;
        vectors++; if (pc_stall !== 1'b1 || imem_req_valid !== 1'b0 || fetch_valid !== 1'b0 || flush_if_id !== 1'b0) begin errors++; $display("FAIL rmw_async: stall=%b req=%b fv=%b fl=%b want 1/0/0/0", pc_stall, imem_req_valid, fetch_valid, flush_if_id); end
        advance();
        rst = 1'b0;
        half();
        vectors++; if (fetch_valid !== 1'b0 || pc_stall !== 1'b1) begin errors++; $display("FAIL rmw_boot: fv=%b stall=%b want 0/1", fetch_valid, pc_stall); end
        advance();
        half();
        vectors++; if (imem_rsp_valid !== 1'b1 || fetch_valid !== 1'b0 || imem_req_valid !== 1'b1 || pc_branch_jump !== 1'b0) begin errors++; $display("FAIL rmw_late_rsp: rsp=%b fv=%b req=%b bj=%b want 1/0/1/0", imem_rsp_valid, fetch_valid, imem_req_valid, pc_branch_jump); end
        advance();
        lat_mode = 1; imem_req_ready = 1;
        half(); advance();
        half();
        vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0 || fetch_instr !== mem_word(32'h0)) begin errors++; $display("FAIL rmw_refetch: fv=%b pc=%h instr=%h want 1/0/%h", fetch_valid, fetch_pc, fetch_instr, mem_word(32'h0)); end
        advance();
    endtask

    // Reference: the next consumed instruction comes from the newest
    // redirect target, otherwise from the previous consumed address + 4.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic        redir;
        logic        consume;
        int          delivered;
        do_reset(); lat_mode = 0;
        half(); advance();
        exp_pc = 0; delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            trap        = ($urandom_range(0, 99) < 5);
            ex_redirect = ($urandom_range(0, 99) < 6);
            id_jump     = ($urandom_range(0, 99) < 6);
            trap_vector = $urandom & 32'hFFFF_FFFC;
            ex_target   = $urandom & 32'hFFFF_FFFC;
            id_target   = $urandom & 32'hFFFF_FFFC;
            hold        = ($urandom_range(0, 99) < 30);
            imem_req_ready = ($urandom_range(0, 99) < 70);
            half();
            redir = trap | ex_redirect | id_jump;
            tgt   = trap ? trap_vector : (ex_redirect ? ex_target : id_target);
            consume = fetch_valid && !hold;
            vectors++; if (mem_busy && imem_req_valid) begin errors++; $display("FAIL rnd_outstanding c%0d: req=%b while busy", i, imem_req_valid); end
            vectors++; if (flush_if_id !== redir) begin errors++; $display("FAIL rnd_flush c%0d: got %b want %b", i, flush_if_id, redir); end
            if (redir) begin
                vectors++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rnd_fv_redir c%0d: got %b want 0", i, fetch_valid); end
            end else begin
                vectors++; if ((!pc_stall && !pc_branch_jump) !== consume) begin errors++; $display("FAIL rnd_advance c%0d: stall=%b bj=%b fv=%b hold=%b", i, pc_stall, pc_branch_jump, fetch_valid, hold); end
            end
            if (pc_branch_jump) begin
                vectors++; if (pc_stall !== 1'b0 || pc_new_pc !== (redir ? tgt : exp_pc)) begin errors++; $display("FAIL rnd_load c%0d: stall=%b npc=%h want 0/%h", i, pc_stall, pc_new_pc, redir ? tgt : exp_pc); end
            end
            if (!redir && consume) begin
                vectors++; if (fetch_pc !== exp_pc || fetch_instr !== mem_word(exp_pc)) begin errors++; $display("FAIL rnd_fetch c%0d: pc=%h instr=%h want %h/%h", i, fetch_pc, fetch_instr, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (redir) exp_pc = tgt;
            advance();
        end
        vectors++; if (delivered < 50) begin errors++; $display("FAIL rnd_liveness: got %0d deliveries want >= 50", delivered); end
        clear_inputs();
    endtask

    initial begin
        vectors = 0; errors = 0; lat_mode = 1;
        mem_force = 0; mem_force_val = 0; mem_busy = 0; mem_cnt = 0; mem_addr = 0;
        pc_q = 0; imem_rsp_valid = 0; imem_rsp_instr = 0;
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_straight_line();
        test_backpressure();
        test_hold();
        test_redirect_wait();
        test_simultaneous();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_seq_ctrl.md
# fetch_seq_ctrl

Fetch sequencer that owns the program counter's control inputs (`stall`, `branch_jump`, `new_pc`) and the instruction-memory request/response handshake. It sits between the PC register, instruction memory, the IF/ID stage and the redirect sources (trap, EX branch resolution, ID jump). It guarantees three things:
- one outstanding fetch at a time;
- redirects are prioritised and applied without ever delivering a stale instruction;
- an instruction returned during a load-use hold is buffered until the hold clears.

## Interface
- `ADDR_W`, 32, PC/target width
- `INSTR_W`, 32, instruction width
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `pc`  in  ADDR_W  current PC register value
- `pc_stall`  out  1  PC hold
- `pc_branch_jump`  out  1  PC load of `pc_new_pc`
- `pc_new_pc`  out  ADDR_W  PC load target
- `imem_req_valid`  out  1  fetch request; address is `pc`
- `imem_req_ready`  in  1  memory accepts request
- `imem_rsp_valid`  in  1  response strobe; exactly one per accepted request, ≥1 cycle after acceptance
- `imem_rsp_instr`  in  INSTR_W  response data
- `trap`, `trap_vector`  in  1/ADDR_W  redirect, priority 1 (highest)
- `ex_redirect`, `ex_target`  in  1/ADDR_W  redirect, priority 2
- `id_jump`, `id_target`  in  1/ADDR_W  redirect, priority 3
- `hold`  in  1  downstream load-use stall; fetch not consumed while high
- `fetch_valid`  out  1  instruction presented to IF/ID
- `fetch_instr`  out  INSTR_W  instruction
- `fetch_pc`  out  ADDR_W  address of `fetch_instr`
- `flush_if_id`  out  1  kill IF/ID contents this cycle

## Operation
- `redir` = trap | ex_redirect | id_jump.
- `tgt` selects the highest-priority asserted target.
- States:
  - BOOT: reset state. Outputs idle, `pc_stall`=1. Next state is ISSUE unconditionally.
  - ISSUE:
    - `imem_req_valid` = !redir.
    - redir: `pc_branch_jump`=1, `pc_new_pc`=tgt, `pc_stall`=0; stay in ISSUE.
    - Else if `imem_req_ready`: go to WAIT. Else stay. `pc_stall`=1 in both cases.
  - WAIT:
    - `rsp_valid` & redir: discard the response, apply tgt, go to ISSUE.
    - `rsp_valid` & !hold: `fetch_valid`=1, `fetch_instr`=rsp, `fetch_pc`=`pc`. PC advances (`pc_stall`=0, `pc_branch_jump`=0), go to ISSUE.
    - `rsp_valid` & hold: capture instr and `pc` into the buffer, go to HOLD.
    - redir without rsp: latch tgt into `pend`, go to KILL.
    - Otherwise stay.
  - HOLD:
    - `fetch_valid`=1 from the buffer.
    - redir: drop the buffer, apply tgt, go to ISSUE.
    - Else if !hold: instruction consumed, PC advances, go to ISSUE.
  - KILL:
    - `fetch_valid`=0.
    - redir overwrites `pend` (newest wins).
    - On `rsp_valid`: discard, apply redir's tgt if redir is asserted this cycle, else `pend`; go to ISSUE.
- "Apply" means `pc_branch_jump`=1, `pc_stall`=0, `pc_new_pc`=target.
- In every state not applying or advancing, `pc_stall`=1 and `pc_branch_jump`=0.
- `flush_if_id` = redir, in any state except BOOT.
- `fetch_valid` is forced 0 in any cycle where redir is high.
- Widths:
  - Targets are passed through unmodified; no alignment check.
  - PC+4 wrap is the PC register's concern.

## Timing
- All outputs are combinational from the registered state and the current inputs. No output is registered except the buffer contents and `pend`.
- Reset values: state=BOOT, buffer and `pend`=0. While in BOOT, `pc_stall`=1 and every other output is 0.
- Reset mid-operation: any outstanding memory response arriving after reset release is ignored (BOOT/ISSUE do not sample `rsp_valid`). The memory side is reset in the same domain.
- Minimum fetch cadence is 2 cycles per instruction:
  - request accepted at cycle N;
  - response at N+1, which advances the PC at the N+1 edge;
  - next request at N+2.
- Redirect latency:
  - In ISSUE/HOLD, the PC is loaded at the edge ending the redirect cycle.
  - In WAIT/KILL without a response, the PC is loaded at the edge ending the response cycle.
- `imem_req_valid` never rises while a request is outstanding (WAIT/KILL).
- Once `imem_req_valid` is asserted in ISSUE, it stays asserted until ready, unless a redirect intervenes.

## Test plan
- Straight-line fetch: ready=1, rsp latency 1, pc starts at 0x0.
  - Expect `fetch_valid` on every second cycle with pc 0x0, 0x4, 0x8, …
  - Expect no flush.
- Backpressure: ready low for 3 cycles in ISSUE.
  - Expect `imem_req_valid` held high and `pc_stall`=1 throughout.
  - Expect the PC to advance only after the response.
- Hold: `rsp_valid` with hold=1 for 4 cycles, instr 0x00500093.
  - Expect HOLD with `fetch_valid`=1 and stable instr/pc for 4 cycles.
  - Expect the PC to advance in the cycle hold drops.
- Redirect during WAIT: ex_redirect to 0x100 two cycles before the response.
  - Expect KILL.
  - Expect the response to be discarded with `fetch_valid`=0.
  - Expect the PC loaded to 0x100 in the response cycle.
- Simultaneous sources: trap (0x80) and id_jump (0x200) in the same ISSUE cycle.
  - Expect `pc_new_pc`=0x80, `imem_req_valid`=0 and `flush_if_id`=1.
- Reset mid-WAIT: assert rst asynchronously.
  - Expect immediate BOOT outputs.
  - Expect a late `rsp_valid` after release to produce no `fetch_valid`.
